// File: rtl/bin2bcd_4dig_if.sv
// bin2bcd_4dig_if
//   Handshake and result bundle between the binary-to-BCD converter and its
//   neighbours.
//   start     : conversion request, honoured only while ready=1
//   bin       : 14-bit unsigned operand, captured on the accepting edge
//   ready     : converter idle, a start will be accepted
//   done_tick : one-cycle pulse, result fields have just been updated
//   bcd3..0   : thousands/hundreds/tens/ones digits for display hex3..hex0
//   ovf       : last completed conversion exceeded 9999 (digits saturated)
//   Modports: master = requester side, slave = converter side.
interface bin2bcd_4dig_if;
   logic        start;
   logic [13:0] bin;
   logic        ready;
   logic        done_tick;
   logic [3:0]  bcd3;
   logic [3:0]  bcd2;
   logic [3:0]  bcd1;
   logic [3:0]  bcd0;
   logic        ovf;

   modport master (
      output start, bin,
      input  ready, done_tick, bcd3, bcd2, bcd1, bcd0, ovf
   );

   modport slave (
      input  start, bin,
      output ready, done_tick, bcd3, bcd2, bcd1, bcd0, ovf
   );
endinterface

// File: rtl/bin2bcd_4dig.sv
// bin2bcd_4dig
//   Sequential 14-bit binary to 4-digit BCD converter (shift-add-3 / double
//   dabble). One conversion takes 14 shift cycles plus a one-cycle DONE state;
//   values above 9999 saturate the digits to 9999 and raise ovf.
//   clk   : rising-edge system clock
//   reset : asynchronous, active-high; returns to IDLE and clears all results
//   bus   : bin2bcd_4dig_if.slave (start/bin in; ready/done_tick/bcd3..0/ovf out)
module bin2bcd_4dig (
   input  logic          clk,
   input  logic          reset,
   bin2bcd_4dig_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OP   = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [13:0] sreg;         // binary operand, shifted out MSB first
   logic [15:0] bcd_w;        // working digits during conversion
   logic [3:0]  cnt;          // shifts remaining
   logic        ovf_pending;  // operand was above 9999
   logic [15:0] bcd_out;      // last completed result, held for the display
   logic        ovf_out;

   logic [15:0] bcd_adj;
   logic [15:0] bcd_shift;

   // Per-digit correction before doubling: a digit of 5 or more would reach
   // 10+ after the shift, so +3 makes it carry into the next digit instead.
   // The sum stays in 4 bits; inputs are at most 9, so nothing is lost.
   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   always_comb begin
      bcd_adj   = {add3(bcd_w[15:12]), add3(bcd_w[11:8]),
                   add3(bcd_w[7:4]),   add3(bcd_w[3:0])};
      bcd_shift = {bcd_adj[14:0], sreg[13]};
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // NOTE: state_next gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start) state_next = OP;
         OP:      if (cnt == 4'd1) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sreg        <= '0;
         bcd_w       <= '0;
         cnt         <= '0;
         ovf_pending <= 1'b0;
         bcd_out     <= '0;
         ovf_out     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  sreg        <= bus.bin;
                  bcd_w       <= '0;
                  cnt         <= 4'd14;
                  ovf_pending <= (bus.bin > 14'd9999);
               end
            end
            OP: begin
               sreg  <= {sreg[12:0], 1'b0};
               bcd_w <= bcd_shift;
               cnt   <= cnt - 4'd1;
               // Last shift: publish straight from the shifted value so the
               // result lands on the same edge as the 14th shift.
               if (cnt == 4'd1) begin
                  bcd_out <= ovf_pending ? 16'h9999 : bcd_shift;
                  ovf_out <= ovf_pending;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ready     = (state == IDLE);
   assign bus.done_tick = (state == DONE);
   assign bus.bcd3      = bcd_out[15:12];
   assign bus.bcd2      = bcd_out[11:8];
   assign bus.bcd1      = bcd_out[7:4];
   assign bus.bcd0      = bcd_out[3:0];
   assign bus.ovf       = ovf_out;

endmodule

// File: tb/tb_bin2bcd_4dig.sv
// tb_bin2bcd_4dig
//   Directed self-checking bench for bin2bcd_4dig. Inputs change #1 after a
//   rising edge; outputs are sampled on falling edges.
module tb_bin2bcd_4dig;

   logic clk = 1'b0;
   logic reset;
   int   cmp_cnt  = 0;
   int   fail_cnt = 0;
   int   cyc      = 0;

   bin2bcd_4dig_if bus ();

   bin2bcd_4dig dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] digits();
      return {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
   endfunction

   // Decimal reference for the stepping sweep.
   function automatic logic [15:0] ref_bcd(input int v);
      if (v > 9999) return 16'h9999;
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for ready at a falling edge, then request conversion.
   // Returns #1 after the accepting edge.
   task automatic launch(input int v, input string tag);
      int tries = 0;
      while (!bus.ready && tries < 40) begin
         @(negedge clk);
         tries++;
      end
      check({tag, "_ready_wait"}, int'(bus.ready), 1);
      bus.bin   = 14'(v);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   // Counts edges after the accepting edge until done_tick is seen.
   task automatic wait_done(output int lat, output int ready_leak);
      lat        = -1;
      ready_leak = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.done_tick) begin
            lat = k;
            break;
         end
         if (bus.ready) ready_leak = 1;
      end
   endtask

   task automatic convert(input int v, input logic [15:0] exp_bcd,
                          input logic exp_ovf, input string tag);
      int lat, leak;
      launch(v, tag);
      wait_done(lat, leak);
      check({tag, "_latency"}, lat, 14);
      check({tag, "_ready_low"}, leak, 0);
      check({tag, "_bcd"}, int'(digits()), int'(exp_bcd));
      check({tag, "_ovf"}, int'(bus.ovf), int'(exp_ovf));
      @(negedge clk);
      check({tag, "_ready_back"}, int'(bus.ready), 1);
      check({tag, "_done_once"}, int'(bus.done_tick), 0);
   endtask

   initial begin
      int lat, leak, extra, prev_acc, acc;

      reset     = 1'b1;
      bus.start = 1'b0;
      bus.bin   = '0;
      @(negedge clk);
      check("rst_ready", int'(bus.ready), 1);
      check("rst_done", int'(bus.done_tick), 0);
      check("rst_bcd", int'(digits()), 0);
      check("rst_ovf", int'(bus.ovf), 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Basic values and saturation.
      convert(0,     16'h0000, 1'b0, "zero");
      convert(1234,  16'h1234, 1'b0, "v1234");
      convert(9999,  16'h9999, 1'b0, "v9999");
      convert(10000, 16'h9999, 1'b1, "v10000");
      convert(16383, 16'h9999, 1'b1, "v16383");
      convert(42,    16'h0042, 1'b0, "v42");

      // start pulses during OP and DONE must be ignored.
      launch(5678, "busy");
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 4) begin
            bus.start = 1'b1;
            bus.bin   = 14'd1111;
         end
         if (k == 5) bus.start = 1'b0;
         if (k == 7) check("busy_hold_prev", int'(digits()), 16'h0042);
         if (bus.done_tick) begin
            lat       = k;
            bus.start = 1'b1;
            bus.bin   = 14'd1111;
            break;
         end
      end
      check("busy_latency", lat, 14);
      check("busy_bcd", int'(digits()), 16'h5678);
      @(posedge clk);
      #1 bus.start = 1'b0;
      extra = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.done_tick) extra++;
      end
      check("busy_no_extra_done", extra, 0);
      check("busy_ready_idle", int'(bus.ready), 1);
      check("busy_result_kept", int'(digits()), 16'h5678);

      // Reset in the 7th OP cycle aborts the conversion.
      launch(4321, "abort");
      for (int k = 1; k <= 6; k++) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort_bcd", int'(digits()), 0);
      check("abort_ovf", int'(bus.ovf), 0);
      check("abort_ready", int'(bus.ready), 1);
      check("abort_done", int'(bus.done_tick), 0);
      @(negedge clk);
      reset = 1'b0;
      extra = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.done_tick) extra++;
      end
      check("abort_no_done", extra, 0);
      convert(4321, 16'h4321, 1'b0, "after_abort");

      // start held high, bin stepping 0..20.
      bus.start = 1'b1;
      prev_acc  = 0;
      for (int i = 0; i <= 20; i++) begin
         int tries = 0;
         while (!bus.ready && tries < 40) begin
            @(negedge clk);
            tries++;
         end
         check("sweep_ready", int'(bus.ready), 1);
         check("sweep_single_done", int'(bus.done_tick), 0);
         bus.bin = 14'(i);
         @(posedge clk);
         #1 acc = cyc;
         if (i > 0) check("sweep_interval", acc - prev_acc, 16);
         prev_acc = acc;
         wait_done(lat, leak);
         check("sweep_latency", lat, 14);
         check("sweep_bcd", int'(digits()), int'(ref_bcd(i)));
         check("sweep_ovf", int'(bus.ovf), 0);
      end
      bus.start = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
      $finish;
   end

endmodule
